// File: rtl/clk_ratio_detect.sv
// Measures the period and high time of a divided clock sampled on clk and
// locks onto its divide ratio (/2, /3, /4, /8) after repeated matching periods.
module clk_ratio_detect #(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned MAX_PERIOD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       din,
  output logic [1:0] ratio,
  output logic [3:0] period,
  output logic [3:0] high_time,
  output logic       locked,
  output logic       upd,
  output logic       err
);

  localparam logic [3:0] MAXP  = 4'(MAX_PERIOD);
  localparam logic [2:0] LOCKV = 3'(LOCK_CNT);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_MEASURE, S_LOCKED} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_din_q;
  logic [3:0] r_cyc_cnt, r_hi_cnt;
  logic [1:0] r_cand, w_cand_nxt;
  logic [2:0] r_match, w_match_nxt, w_match_inc;
  logic       r_tmo_done, w_tmo_set;
  logic [1:0] r_ratio, w_ratio_nxt;
  logic [3:0] r_period, w_period_nxt, r_high, w_high_nxt;
  logic       r_locked, w_locked_nxt, r_upd, w_upd_nxt, r_err, w_err_nxt;
  logic       w_rise, w_timeout, w_valid;
  logic [1:0] w_code;

  assign w_rise    = din & ~r_din_q;
  // A saturated counter only times out once until the next edge re-arms it.
  assign w_timeout = (r_cyc_cnt == MAXP) & ~r_tmo_done;

  always_comb begin
    w_valid = 1'b0;
    w_code  = 2'd0;
    if (r_hi_cnt == 4'd1) begin
      case (r_cyc_cnt)
        4'd2: begin w_valid = 1'b1; w_code = 2'd1; end
        4'd3: begin w_valid = 1'b1; w_code = 2'd0; end
        4'd4: begin w_valid = 1'b1; w_code = 2'd2; end
        4'd8: begin w_valid = 1'b1; w_code = 2'd3; end
        default: ;
      endcase
    end
  end

  assign w_match_inc = (w_code == r_cand) ? r_match + 3'd1 : 3'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_cand_nxt   = r_cand;
    w_match_nxt  = r_match;
    w_ratio_nxt  = r_ratio;
    w_period_nxt = r_period;
    w_high_nxt   = r_high;
    w_locked_nxt = r_locked;
    w_upd_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    w_tmo_set    = 1'b0;
    if (!en) begin
      w_state_nxt  = S_IDLE;
      w_locked_nxt = 1'b0;
      w_match_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_ARMED;
        S_ARMED: begin
          if (w_rise) begin
            w_state_nxt = S_MEASURE;
            w_match_nxt = '0;
          end else if (w_timeout) begin
            w_err_nxt   = 1'b1;
            w_tmo_set   = 1'b1;
            w_match_nxt = '0;
          end
        end
        default: begin
          if (w_rise) begin
            w_upd_nxt    = 1'b1;
            w_period_nxt = r_cyc_cnt;
            w_high_nxt   = r_hi_cnt;
            if (!w_valid) begin
              w_err_nxt    = 1'b1;
              w_match_nxt  = '0;
              w_locked_nxt = 1'b0;
              w_state_nxt  = S_MEASURE;
            end else if (r_state == S_LOCKED) begin
              if (w_code != r_ratio) begin
                w_err_nxt    = 1'b1;
                w_locked_nxt = 1'b0;
                w_cand_nxt   = w_code;
                w_match_nxt  = 3'd1;
                w_state_nxt  = S_MEASURE;
              end
            end else begin
              w_cand_nxt  = w_code;
              w_match_nxt = w_match_inc;
              if (w_match_inc == LOCKV) begin
                w_state_nxt  = S_LOCKED;
                w_locked_nxt = 1'b1;
                w_ratio_nxt  = w_code;
              end
            end
          end else if (w_timeout) begin
            w_err_nxt    = 1'b1;
            w_tmo_set    = 1'b1;
            w_locked_nxt = 1'b0;
            w_match_nxt  = '0;
            w_state_nxt  = S_ARMED;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_din_q    <= 1'b0;
      r_cyc_cnt  <= '0;
      r_hi_cnt   <= '0;
      r_cand     <= '0;
      r_match    <= '0;
      r_tmo_done <= 1'b0;
      r_ratio    <= '0;
      r_period   <= '0;
      r_high     <= '0;
      r_locked   <= 1'b0;
      r_upd      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_din_q   <= din;
      if (w_rise) r_cyc_cnt <= 4'd1;
      else if (r_cyc_cnt < MAXP) r_cyc_cnt <= r_cyc_cnt + 4'd1;
      if (w_rise) r_hi_cnt <= 4'd1;
      else if (din && r_hi_cnt != 4'd15) r_hi_cnt <= r_hi_cnt + 4'd1;
      if (w_rise) r_tmo_done <= 1'b0;
      else if (w_tmo_set) r_tmo_done <= 1'b1;
      r_cand    <= w_cand_nxt;
      r_match   <= w_match_nxt;
      r_ratio   <= w_ratio_nxt;
      r_period  <= w_period_nxt;
      r_high    <= w_high_nxt;
      r_locked  <= w_locked_nxt;
      r_upd     <= w_upd_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign ratio     = r_ratio;
  assign period    = r_period;
  assign high_time = r_high;
  assign locked    = r_locked;
  assign upd       = r_upd;
  assign err       = r_err;

endmodule
